// File: rtl/color_manager_cfg_arbiter_pkg.sv
// Shared constants for the Color Manager config-bus arbiter: bus widths, config
// addresses, the active-low strobe level and the arbiter FSM encoding.
`ifndef ACTIVE
`define ACTIVE 1'b0
`endif

package color_manager_cfg_arbiter_pkg;

    localparam int C_ADDR_WIDTH = 4;
    localparam int C_DATA_WIDTH = 8;

    localparam logic [C_ADDR_WIDTH-1:0] ADDR_VGA_CONFIG  = 4'h0;
    localparam logic [C_ADDR_WIDTH-1:0] ADDR_VGA_COLOR   = 4'h1;
    localparam logic [C_ADDR_WIDTH-1:0] ADDR_VGA_QUADRAN = 4'h2;

    localparam logic [C_DATA_WIDTH-1:0] CFG_R8X6 = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } cm_state_e;

    // Round-robin pointer advance: the slot after the winner, wrapping at num_req.
    function automatic logic [1:0] rr_next(input logic [1:0] winner, input int num_req);
        rr_next = (int'(winner) + 1 == num_req) ? 2'd0 : winner + 2'd1;
    endfunction

endpackage

// File: rtl/color_manager_cfg_arbiter_if.sv
// Requester-side and Color Manager config-bus signals of the arbiter.
// master = arbiter side, slave = requesters plus Color Manager side.
interface color_manager_cfg_arbiter_if
    import color_manager_cfg_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*C_ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*C_DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]              req_done;
    logic                            req_err;
    logic [1:0]                      grant_id;
    logic                            busy;
    logic [C_ADDR_WIDTH-1:0]         c_addr;
    logic [C_DATA_WIDTH-1:0]         c_data;
    logic                            c_valid;
    logic                            c_rdy;

    modport master (
        input  req_valid, req_addr, req_data, c_rdy,
        output req_done, req_err, grant_id, busy, c_addr, c_data, c_valid
    );

    modport slave (
        output req_valid, req_addr, req_data, c_rdy,
        input  req_done, req_err, grant_id, busy, c_addr, c_data, c_valid
    );
endinterface

// File: rtl/color_manager_cfg_arbiter_cm_rr_picker.sv
// Combinational rotate-priority picker: first set request at or after the
// round-robin pointer, wrapping modulo NUM_REQ.
module cm_rr_picker #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [1:0]         i_rr_ptr,
    output logic [1:0]         o_winner,
    output logic               o_found
);

    logic [3:0] w_req4;
    logic [2:0] w_sum;

    assign w_req4 = 4'(i_req_valid);

    // Walk from the farthest slot back to the pointer so the nearest hit wins.
    always_comb begin
        o_winner = 2'd0;
        o_found  = 1'b0;
        w_sum    = 3'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_rr_ptr} + 3'(k);
            if (w_sum >= 3'(NUM_REQ)) begin
                w_sum = w_sum - 3'(NUM_REQ);
            end
            if (w_req4[w_sum[1:0]]) begin
                o_found  = 1'b1;
                o_winner = w_sum[1:0];
            end
        end
    end

endmodule

// File: rtl/color_manager_cfg_arbiter.sv
// Round-robin arbiter sharing the Color Manager config bus between NUM_REQ requesters.
// Optional WAIT timeout enabled by defining CFG_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | pick next requester, load C_Addr/C_Data, strobe C_Valid
// ST_ISSUE | C_Valid low for this single cycle
// ST_WAIT  | wait for the registered ack (or timeout)
// ST_DONE  | Req_Done pulse to the granted requester, no arbitration
module color_manager_cfg_arbiter
    import color_manager_cfg_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 8,
    parameter int TO_WIDTH       = 4
) (
    input  logic                         Clk,
    input  logic                         rst_n,
    color_manager_cfg_arbiter_if.master  cm_bus
);

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1 ||
        TIMEOUT_CYCLES >= (1 << TO_WIDTH)) begin : g_bad_params
        $error("color_manager_cfg_arbiter: NUM_REQ or timeout parameters out of range");
    end

    cm_state_e               r_state, w_state_nxt;
    logic [1:0]              r_rr_ptr, w_rr_ptr_nxt;
    logic [1:0]              r_grant_id, w_grant_nxt;
    logic [C_ADDR_WIDTH-1:0] r_c_addr, w_addr_nxt, w_sel_addr;
    logic [C_DATA_WIDTH-1:0] r_c_data, w_data_nxt, w_sel_data;
    logic                    r_c_valid, w_c_valid_nxt;
    logic [NUM_REQ-1:0]      r_req_done, w_done_nxt, w_done_onehot;
    logic                    r_busy, w_busy_nxt;
    logic [1:0]              w_winner;
    logic                    w_found;
`ifdef CFG_TIMEOUT_EN
    logic                    r_req_err, w_err_nxt;
    logic [TO_WIDTH-1:0]     r_to_cnt, w_to_cnt_nxt;
`endif

    cm_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_req_valid (cm_bus.req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_winner    (w_winner),
        .o_found     (w_found)
    );

    assign w_done_onehot = NUM_REQ'(1) << r_grant_id;

    // Constant-index mux keeps the flat bus slicing free of variable part-selects.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == 2'(i)) begin
                w_sel_addr = cm_bus.req_addr[i*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                w_sel_data = cm_bus.req_data[i*C_DATA_WIDTH +: C_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_grant_nxt   = r_grant_id;
        w_addr_nxt    = r_c_addr;
        w_data_nxt    = r_c_data;
        w_c_valid_nxt = ~`ACTIVE;
        w_done_nxt    = '0;
`ifdef CFG_TIMEOUT_EN
        w_err_nxt     = r_req_err;
        w_to_cnt_nxt  = r_to_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt   = ST_ISSUE;
                    w_grant_nxt   = w_winner;
                    w_addr_nxt    = w_sel_addr;
                    w_data_nxt    = w_sel_data;
                    w_c_valid_nxt = `ACTIVE;
                    w_rr_ptr_nxt  = rr_next(w_winner, NUM_REQ);
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
`ifdef CFG_TIMEOUT_EN
                w_to_cnt_nxt = '0;
`endif
            end
            ST_WAIT: begin
                if (cm_bus.c_rdy == `ACTIVE) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = w_done_onehot;
`ifdef CFG_TIMEOUT_EN
                    w_err_nxt   = 1'b0;
                end else if (r_to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    // Last allowed WAIT cycle without ack: abort with error.
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = w_done_onehot;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
`endif
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= 2'd0;
            r_grant_id <= 2'd0;
            r_c_addr   <= '0;
            r_c_data   <= '0;
            r_c_valid  <= ~`ACTIVE;
            r_req_done <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant_id <= w_grant_nxt;
            r_c_addr   <= w_addr_nxt;
            r_c_data   <= w_data_nxt;
            r_c_valid  <= w_c_valid_nxt;
            r_req_done <= w_done_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

`ifdef CFG_TIMEOUT_EN
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_err <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_req_err <= w_err_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
        end
    end
    assign cm_bus.req_err = r_req_err;
`else
    assign cm_bus.req_err = 1'b0;
`endif

    assign cm_bus.req_done = r_req_done;
    assign cm_bus.grant_id = r_grant_id;
    assign cm_bus.busy     = r_busy;
    assign cm_bus.c_addr   = r_c_addr;
    assign cm_bus.c_data   = r_c_data;
    assign cm_bus.c_valid  = r_c_valid;

endmodule
